// File: rtl/fir_stereo_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stereo_scheduler
//  Function : Shares one FIR MAC engine between the left and right channels:
//             latch pair, write buffers, run left then right, present both.
//  Revision : 1.0
// ============================================================================
module fir_stereo_scheduler #(
    parameter int DW          = 18,
    parameter int MAC_TIMEOUT = 4096
) (
    input  logic          clockext100MHz,
    input  logic          reset,
    input  logic          datain_ready,
    input  logic [DW-1:0] left_in,
    input  logic [DW-1:0] right_in,
    output logic          cb_wen,
    output logic [DW-1:0] cb_left_din,
    output logic [DW-1:0] cb_right_din,
    output logic          mac_start,
    output logic          mac_chsel,
    input  logic          mac_done,
    input  logic [DW-1:0] mac_result,
    output logic [DW-1:0] left_out,
    output logic [DW-1:0] right_out,
    output logic          dataout_ready,
    output logic          busy,
    input  logic          flag_clr,
    output logic          overrun,
    output logic          timeout
);

    localparam int                 c_cnt_w    = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAC_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_START_L = 3'd2,
        S_WAIT_L  = 3'd3,
        S_START_R = 3'd4,
        S_WAIT_R  = 3'd5,
        S_OUT     = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]        cb_left_din_q, cb_left_din_d;
    logic [DW-1:0]        cb_right_din_q, cb_right_din_d;
    logic [DW-1:0]        left_res_q, left_res_d;
    logic [DW-1:0]        right_res_q, right_res_d;
    logic [DW-1:0]        left_out_q, left_out_d;
    logic [DW-1:0]        right_out_q, right_out_d;
    logic                 cb_wen_q, cb_wen_d;
    logic                 mac_start_q, mac_start_d;
    logic                 mac_chsel_q, mac_chsel_d;
    logic                 dataout_ready_q, dataout_ready_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cb_left_din_d  = cb_left_din_q;
        cb_right_din_d = cb_right_din_q;
        left_res_d     = left_res_q;
        right_res_d    = right_res_q;
        left_out_d     = left_out_q;
        right_out_d    = right_out_q;
        overrun_d      = overrun_q & ~flag_clr;
        timeout_d      = timeout_q & ~flag_clr;

        case (state_q)
            S_IDLE: begin
                if (datain_ready) begin
                    cb_left_din_d  = left_in;
                    cb_right_din_d = right_in;
                    state_d        = S_WRITE;
                end
            end
            S_WRITE:   state_d = S_START_L;
            S_START_L: begin
                cnt_d   = '0;
                state_d = S_WAIT_L;
            end
            S_WAIT_L: begin
                // A done arriving on the expiry cycle still counts as a result.
                if (mac_done) begin
                    left_res_d = mac_result;
                    state_d    = S_START_R;
                end else if (cnt_q == c_cnt_last) begin
                    left_res_d = '0;
                    timeout_d  = 1'b1;
                    state_d    = S_START_R;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_START_R: begin
                cnt_d   = '0;
                state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (mac_done) begin
                    right_res_d = mac_result;
                    state_d     = S_OUT;
                end else if (cnt_q == c_cnt_last) begin
                    right_res_d = '0;
                    timeout_d   = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && datain_ready) begin
            overrun_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        if (state_d == S_OUT) begin
            left_out_d  = left_res_d;
            right_out_d = right_res_d;
        end
        cb_wen_d        = (state_d == S_WRITE);
        mac_start_d     = (state_d == S_START_L) || (state_d == S_START_R);
        mac_chsel_d     = (state_d == S_START_R) || (state_d == S_WAIT_R);
        dataout_ready_d = (state_d == S_OUT);
        busy_d          = (state_d != S_IDLE);
    end

    always_ff @(posedge clockext100MHz or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            cb_left_din_q   <= '0;
            cb_right_din_q  <= '0;
            left_res_q      <= '0;
            right_res_q     <= '0;
            left_out_q      <= '0;
            right_out_q     <= '0;
            cb_wen_q        <= 1'b0;
            mac_start_q     <= 1'b0;
            mac_chsel_q     <= 1'b0;
            dataout_ready_q <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cb_left_din_q   <= cb_left_din_d;
            cb_right_din_q  <= cb_right_din_d;
            left_res_q      <= left_res_d;
            right_res_q     <= right_res_d;
            left_out_q      <= left_out_d;
            right_out_q     <= right_out_d;
            cb_wen_q        <= cb_wen_d;
            mac_start_q     <= mac_start_d;
            mac_chsel_q     <= mac_chsel_d;
            dataout_ready_q <= dataout_ready_d;
            busy_q          <= busy_d;
            overrun_q       <= overrun_d;
            timeout_q       <= timeout_d;
        end
    end

    assign cb_wen        = cb_wen_q;
    assign cb_left_din   = cb_left_din_q;
    assign cb_right_din  = cb_right_din_q;
    assign mac_start     = mac_start_q;
    assign mac_chsel     = mac_chsel_q;
    assign left_out      = left_out_q;
    assign right_out     = right_out_q;
    assign dataout_ready = dataout_ready_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_stereo_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_stereo_scheduler
//  Function : Vector table, corner sequences and random pairs for the scheduler.
//  Revision : 1.0
// ============================================================================
module tb_fir_stereo_scheduler;

    localparam int DW = 18;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          reset, datain_ready, flag_clr, mac_done;
    logic [DW-1:0] left_in, right_in, mac_result;
    logic          cb_wen, mac_start, mac_chsel, dataout_ready, busy, overrun, timeout;
    logic [DW-1:0] cb_left_din, cb_right_din, left_out, right_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Engine model controls, written only by the main sequence.
    int            eng_kl, eng_kr;
    logic [DW-1:0] eng_rl, eng_rr;
    logic          stray_req;

    typedef struct {
        logic [DW-1:0] l, r, rl, rr, lo, ro;
        int            kl, kr, ovr_at, sr, lat;
        bit            stray, to, ovr;
    } vec_t;

    vec_t vec [9];

    always #5 clk = ~clk;

    fir_stereo_scheduler #(.DW(DW), .MAC_TIMEOUT(T)) dut (
        .clockext100MHz(clk),
        .reset         (reset),
        .datain_ready  (datain_ready),
        .left_in       (left_in),
        .right_in      (right_in),
        .cb_wen        (cb_wen),
        .cb_left_din   (cb_left_din),
        .cb_right_din  (cb_right_din),
        .mac_start     (mac_start),
        .mac_chsel     (mac_chsel),
        .mac_done      (mac_done),
        .mac_result    (mac_result),
        .left_out      (left_out),
        .right_out     (right_out),
        .dataout_ready (dataout_ready),
        .busy          (busy),
        .flag_clr      (flag_clr),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    // Engine: done k cycles after a start; a new start cancels a pending one.
    initial begin : engine
        int            cnt;
        logic [DW-1:0] res;
        cnt = 0; res = '0; mac_done = 1'b0; mac_result = '0;
        forever begin
            @(negedge clk);
            mac_done   = 1'b0;
            mac_result = DW'($urandom);
            if (!reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mac_done   = 1'b1;
                        mac_result = res;
                    end
                end
                if (mac_start) begin
                    cnt = mac_chsel ? eng_kr : eng_kl;
                    res = mac_chsel ? eng_rr : eng_rl;
                end
                if (stray_req) begin
                    mac_done   = 1'b1;
                    mac_result = 18'h2BEEF;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [DW-1:0] l, r, rl, rr, input int kl, kr, ovr_at,
                                input bit stray, input logic [DW-1:0] lo, ro, input bit to, ovr,
                                input int sr, lat);
        vec_t v;
        v.l = l; v.r = r; v.rl = rl; v.rr = rr; v.kl = kl; v.kr = kr; v.ovr_at = ovr_at;
        v.stray = stray; v.lo = lo; v.ro = ro; v.to = to; v.ovr = ovr; v.sr = sr; v.lat = lat;
        return v;
    endfunction

    // Reference: a channel that misses its deadline costs exactly T wait cycles and yields 0.
    function automatic bit late(input int k);
        return (k == 0) || (k > T);
    endfunction

    function automatic int wait_len(input int k);
        return late(k) ? T : k;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t m;
        m     = v;
        m.lo  = late(v.kl) ? '0 : v.rl;
        m.ro  = late(v.kr) ? '0 : v.rr;
        m.to  = late(v.kl) || late(v.kr);
        m.sr  = 3 + wait_len(v.kl);
        m.lat = 4 + wait_len(v.kl) + wait_len(v.kr);
        m.ovr = (v.ovr_at >= 1) && (v.ovr_at <= m.lat);
        return m;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, " left_out"}, left_out, 0);
        chk({tag, " right_out"}, right_out, 0);
        chk({tag, " cb_left_din"}, cb_left_din, 0);
        chk({tag, " cb_right_din"}, cb_right_din, 0);
        chk({tag, " ctrl"}, {cb_wen, mac_start, mac_chsel, dataout_ready, busy}, 0);
        chk({tag, " flags"}, {overrun, timeout}, 0);
    endtask

    // Called at posedge+1 with the DUT idle; this cycle is cycle 0.
    task automatic run_pair(input vec_t v, input string tag);
        int            c, wen_c, extra_wen, st_l, st_r, out_c, chsel_bad;
        logic          chl, chr, to_f;
        logic [DW-1:0] lo, ro;
        wen_c = -1; extra_wen = 0; st_l = -1; st_r = -1; out_c = -1; chsel_bad = 0;
        chl = 1'b1; chr = 1'b0; to_f = 1'b0; lo = '0; ro = '0;
        eng_kl = v.kl; eng_kr = v.kr; eng_rl = v.rl; eng_rr = v.rr;
        left_in = v.l; right_in = v.r; datain_ready = 1'b1; flag_clr = 1'b1;
        stray_req = v.stray;
        c = 0;
        while (out_c < 0 && c < 100) begin
            @(posedge clk); #1; c++;
            datain_ready = (c == v.ovr_at);
            flag_clr     = 1'b0;
            stray_req    = v.stray && (c == 2);
            left_in      = DW'($urandom);
            right_in     = DW'($urandom);
            if (cb_wen) begin
                if (wen_c < 0) wen_c = c;
                else extra_wen++;
            end
            if (c == 1) begin
                chk({tag, " cb_left_din"}, cb_left_din, v.l);
                chk({tag, " cb_right_din"}, cb_right_din, v.r);
            end
            if (mac_start) begin
                if (st_l < 0) begin st_l = c; chl = mac_chsel; end
                else begin st_r = c; chr = mac_chsel; end
            end
            if (mac_chsel !== ((c >= v.sr) && (c < v.lat))) chsel_bad++;
            if (v.ovr_at > 0 && c == v.ovr_at + 1 && c <= v.lat)
                chk({tag, " overrun rise"}, overrun, 1);
            if (dataout_ready) begin
                out_c = c; lo = left_out; ro = right_out; to_f = timeout;
            end
        end
        @(posedge clk); #1;
        datain_ready = 1'b0;
        stray_req    = 1'b0;
        chk({tag, " cb_wen cycle"}, wen_c, 1);
        chk({tag, " extra cb_wen"}, extra_wen, 0);
        chk({tag, " start_l cycle"}, st_l, 2);
        chk({tag, " start_l chsel"}, chl, 0);
        chk({tag, " start_r cycle"}, st_r, v.sr);
        chk({tag, " start_r chsel"}, chr, 1);
        chk({tag, " chsel profile errors"}, chsel_bad, 0);
        chk({tag, " dataout_ready cycle"}, out_c, v.lat);
        chk({tag, " left_out"}, lo, v.lo);
        chk({tag, " right_out"}, ro, v.ro);
        chk({tag, " timeout"}, to_f, v.to);
        chk({tag, " busy after out"}, busy, 0);
        chk({tag, " overrun"}, overrun, v.ovr);
        chk({tag, " cb_left_din held"}, cb_left_din, v.l);
        chk({tag, " left_out held"}, left_out, v.lo);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int saw;
        vec[0] = mk(18'h00123, 18'h3FF00, 18'h00AAA, 18'h15555,  5, 5, -1, 0, 18'h00AAA, 18'h15555, 0, 0,  8, 14);
        vec[1] = mk(18'h00123, 18'h3FF00, 18'h00AAA, 18'h15555,  5, 5,  6, 0, 18'h00AAA, 18'h15555, 0, 1,  8, 14);
        vec[2] = mk(18'h1FFFF, 18'h20000, 18'h2AAAA, 18'h00001,  1, 1, -1, 0, 18'h2AAAA, 18'h00001, 0, 0,  4,  6);
        vec[3] = mk(18'h00011, 18'h00022, 18'h12345, 18'h3FFFF,  3, 0, -1, 0, 18'h12345, 18'h00000, 1, 0,  6, 23);
        vec[4] = mk(18'h00033, 18'h00044, 18'h3FFFF, 18'h00010, 16, 2, -1, 0, 18'h3FFFF, 18'h00010, 0, 0, 19, 22);
        vec[5] = mk(18'h00055, 18'h00066, 18'h11111, 18'h22222, 17, 4, -1, 0, 18'h00000, 18'h22222, 1, 0, 19, 24);
        vec[6] = mk(18'h00077, 18'h00088, 18'h0ABCD, 18'h1DCBA,  4, 3, -1, 1, 18'h0ABCD, 18'h1DCBA, 0, 0,  7, 11);
        vec[7] = mk(18'h00099, 18'h000AA, 18'h00003, 18'h00004,  0, 0, -1, 0, 18'h00000, 18'h00000, 1, 0, 19, 36);
        vec[8] = mk(18'h000BB, 18'h000CC, 18'h00001, 18'h00002,  2, 2,  8, 0, 18'h00001, 18'h00002, 0, 1,  5,  8);

        reset = 1'b0; datain_ready = 1'b0; flag_clr = 1'b0; stray_req = 1'b0;
        left_in = '0; right_in = '0; eng_kl = 1; eng_kr = 1; eng_rl = '0; eng_rr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_pair(vec[i], $sformatf("vec%0d", i));

        // Sticky overrun: plain clear, then set and clear in the same cycle.
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("flag_clr idle", overrun, 0);
        eng_kl = 2; eng_kr = 2; eng_rl = 18'h15A5A; eng_rr = 18'h0A5A5;
        left_in = 18'h00F00; right_in = 18'h000F0; datain_ready = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b1;
        @(posedge clk); #1;
        datain_ready = 1'b0;
        chk("set beats clear", overrun, 1);
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("clear while busy", overrun, 0);
        saw = 0;
        for (int k = 0; k < 50 && saw == 0; k++) begin
            @(posedge clk); #1;
            if (dataout_ready) saw = 1;
        end
        chk("flag seq dataout_ready", saw, 1);
        chk("flag seq left_out", left_out, 18'h15A5A);
        @(posedge clk); #1;

        // Reset during WAIT_R with overrun set and results on the outputs.
        eng_kl = 2; eng_kr = 10; eng_rl = 18'h0F0F0; eng_rr = 18'h30303;
        left_in = 18'h01234; right_in = 18'h04321; datain_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            datain_ready = (c == 4);
        end
        chk("pre-reset chsel", mac_chsel, 1);
        chk("pre-reset busy", busy, 1);
        chk("pre-reset overrun", overrun, 1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        saw = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dataout_ready) saw++;
        end
        chk("no spurious dataout_ready", saw, 0);
        chk("idle after reset", busy, 0);
        run_pair(vec[0], "post_reset");

        for (int n = 0; n < 40; n++) begin
            vec_t v;
            v = mk(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                   int'($urandom_range(0, T + 2)), int'($urandom_range(0, T + 2)), -1,
                   bit'($urandom_range(0, 1)), '0, '0, 0, 0, 0, 0);
            v = model(v);
            if ($urandom_range(0, 3) == 0) begin
                v.ovr_at = int'($urandom_range(1, v.lat));
                v = model(v);
            end
            run_pair(v, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
